vga_pixel_pipe: RTL and testbench
=================================

# vga_pixel_pipe

Parametrised pixel pipeline between the VGA timing generator and the DVI/VGA output stage. It generates framebuffer read addresses from the current scan position, with optional 2x pixel doubling. It maps returned palette indices through a run-time writable palette and delays de/hsync/vsync so they stay aligned with `color`. It replaces the fixed 800x480, 4-bit, read-only-palette colour path.

## Interface
Parameters:
- `H_RES`, 800: active pixels per line.
- `V_RES`, 480: active lines per frame.
- `INDEX_W`, 4: palette index width; palette depth is 2^INDEX_W.
- `COLOR_W`, 15: output colour width, RGB with equal channels, CH_W = COLOR_W/3; CH_W >= INDEX_W is required.
- `FB_DEPTH`, 384000: framebuffer words actually present (192000 on a35t).
- `FB_ADDR_W`, 19: framebuffer address width.
- `RAM_LATENCY`, 1: cycles from `fb_addr` to valid `fb_data`, minimum 1.
- `WR_ANYTIME`, 0: 1 = palette writable during active video; 0 = vertical blanking only.

Ports:
- `pixel_clk`  in  1  sole clock.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `sx`, `sy`  in  10 each  scan position from the timing generator.
- `de_in`, `hsync_in`, `vsync_in`  in  1 each  raw timing signals matching sx/sy.
- `scale2x`  in  1  mode request: 0 = 1x, 1 = 2x pixel/line doubling.
- `fb_addr`  out  FB_ADDR_W  framebuffer read address.
- `fb_data`  in  INDEX_W  palette index returned RAM_LATENCY cycles after `fb_addr`.
- `pal_wr_valid`  in  1  palette write request.
- `pal_wr_ready`  out  1  palette write can be accepted.
- `pal_wr_index`  in  INDEX_W  entry to write.
- `pal_wr_color`  in  COLOR_W  value to write.
- `color`  out  COLOR_W  pixel colour.
- `de_out`, `hsync_out`, `vsync_out`  out  1 each  delayed timing aligned with `color`.

## Operation
- FSM states INIT and RUN. Reset enters INIT with init counter 0.
- INIT: writes palette[k] one entry per cycle, k = 0 .. 2^INDEX_W-1. Each channel of the entry is k << (CH_W-INDEX_W).
  - During INIT: `pal_wr_ready`=0, `color`=0, `fb_addr`=0.
  - After the last entry, the FSM moves to RUN and never leaves it except through reset.
- Mode latch `scale_q`:
  - Reset value 0.
  - Loaded from `scale2x` only on the cycle sx==0 && sy==0, so a mode change never tears mid-frame.
- Address, with s = scale_q and W_SRC = H_RES >> s:
  - In the active area (sx < H_RES && sy < V_RES): A = (sy>>s)*W_SRC + (sx>>s).
  - Outside the active area: A = 0.
  - If A >= FB_DEPTH: `fb_addr` = 0 and an `oob` flag travels down the pipe with the pixel.
  - Implementation choice (multiply or incremental row base) is free; `fb_addr` is registered.
- Palette write:
  - Handshake fires on `pal_wr_valid && pal_wr_ready`.
  - `pal_wr_ready` = RUN && (WR_ANYTIME || sy >= V_RES).
  - The written entry is visible to a lookup issued the next cycle.
  - If a write and a lookup hit the same index in the same cycle, the lookup returns the old value.
- Colour:
  - `color` = palette[fb_data] when the delayed de is 1 and oob is 0.
  - Otherwise `color` = 0.

## Timing
- sx/sy → `fb_addr`: 1 cycle.
- `fb_addr` → `fb_data`: RAM_LATENCY cycles.
- `fb_data` → `color`: 1 cycle.
- Total latency L = 2 + RAM_LATENCY. `de_out`/`hsync_out`/`vsync_out` equal their inputs delayed exactly L cycles.
- Reset values of all outputs: `fb_addr`=0, `color`=0, `de_out`=0, `hsync_out`=0, `vsync_out`=0, `pal_wr_ready`=0.
- The pipeline delay registers clear on reset. Sync outputs during the first L cycles after reset are 0.
- INIT lasts exactly 2^INDEX_W cycles after `rst_n` rises. `pal_wr_ready` can rise on cycle 2^INDEX_W at the earliest.
- Reset asserted mid-INIT or mid-frame: all outputs go to reset values immediately and INIT restarts from k=0.
- `pal_wr_ready` is combinational from state and sy. A write with ready=0 is held off, never dropped; the requester keeps `pal_wr_valid` high.

## Test plan
- Reset release, INDEX_W=4, COLOR_W=15 → `pal_wr_ready`=0 for 16 cycles. A readback of entry 5 then gives channel 5<<1=10 → `color`=15'h294A.
- 1x mode, sx=10, sy=2, de_in=1 → `fb_addr`=1610 one cycle later. `color` and `de_out`=1 arrive L=3 cycles after the input.
- `scale2x`=1 set at sx=300 mid-frame → no change until the next (0,0). In the next frame, sx=21, sy=5 → `fb_addr`=2*400+10=810.
- `pal_wr_valid` at sy=100 with WR_ANYTIME=0 → ready=0, palette unchanged. At sy=480 the write of index 3 = 15'h7C00 is accepted, and a pixel with index 3 then shows 15'h7C00.
- FB_DEPTH=192000, sx=0, sy=240 → `fb_addr`=0 and `color`=0 while `de_out`=1.
- Reset pulse at INIT k=7 → INIT restarts. Full ramp is present and outputs are 0 until RUN.

Source files
------------

// File: rtl/vga_pixel_pipe_if.sv
`default_nettype none
// ============================================================================
// Module  : vga_pixel_pipe_if
// Brief   : Framebuffer read port and palette write handshake of the pixel pipe
// Revision: 1.0 - initial release
// ============================================================================
interface vga_pixel_pipe_if #(
  parameter int INDEX_W   = 4,
  parameter int COLOR_W   = 15,
  parameter int FB_ADDR_W = 19
);
  logic [FB_ADDR_W-1:0] fb_addr;
  logic [INDEX_W-1:0]   fb_data;
  logic                 pal_wr_valid;
  logic                 pal_wr_ready;
  logic [INDEX_W-1:0]   pal_wr_index;
  logic [COLOR_W-1:0]   pal_wr_color;

  // master: framebuffer RAM and palette writer; slave: the pixel pipe
  modport master (
    input  fb_addr, pal_wr_ready,
    output fb_data, pal_wr_valid, pal_wr_index, pal_wr_color
  );

  modport slave (
    output fb_addr, pal_wr_ready,
    input  fb_data, pal_wr_valid, pal_wr_index, pal_wr_color
  );
endinterface
`default_nettype wire

// File: rtl/vga_pixel_pipe.sv
`default_nettype none
// ============================================================================
// Module  : vga_pixel_pipe
// Brief   : Scan position -> framebuffer address -> palette colour, with 2x
//           doubling, writable palette and timing delayed to match colour
// Revision: 1.0 - initial release
// ============================================================================
module vga_pixel_pipe #(
  parameter int H_RES       = 800,
  parameter int V_RES       = 480,
  parameter int INDEX_W     = 4,
  parameter int COLOR_W     = 15,
  parameter int FB_DEPTH    = 384000,
  parameter int FB_ADDR_W   = 19,
  parameter int RAM_LATENCY = 1,
  parameter int WR_ANYTIME  = 0
) (
  input  wire                 pixel_clk,
  input  wire                 rst_n,
  input  wire  [9:0]          sx,
  input  wire  [9:0]          sy,
  input  wire                 de_in,
  input  wire                 hsync_in,
  input  wire                 vsync_in,
  input  wire                 scale2x,
  vga_pixel_pipe_if.slave     bus,
  output logic [COLOR_W-1:0]  color,
  output logic                de_out,
  output logic                hsync_out,
  output logic                vsync_out
);

  localparam int c_ch_w      = COLOR_W / 3;
  localparam int c_pal_depth = 2 ** INDEX_W;
  localparam int c_lat       = 2 + RAM_LATENCY;
  localparam logic [INDEX_W-1:0] c_k_last = '1;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 w_run;
  logic [INDEX_W-1:0]   r_init_k;
  logic                 r_scale;
  logic [FB_ADDR_W-1:0] r_fb_addr;
  logic [COLOR_W-1:0]   r_color;
  logic [COLOR_W-1:0]   r_pal [c_pal_depth];
  logic [c_lat-1:0][2:0]     r_sync;
  logic [RAM_LATENCY:0]      r_oob;
  logic [c_ch_w-1:0]    w_init_ch;
  logic [COLOR_W-1:0]   w_init_color;
  logic                 w_pal_we;
  logic [31:0]          w_row;
  logic [31:0]          w_col;
  logic [31:0]          w_wsrc;
  logic [31:0]          w_addr;
  logic                 w_active;
  logic                 w_oob;
  logic                 w_de_lk;
  logic                 w_oob_lk;

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_INIT;
      r_init_k <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_INIT)
        r_init_k <= r_init_k + INDEX_W'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_run       = 1'b0;
    case (r_state)
      ST_INIT: if (r_init_k == c_k_last) w_state_nxt = ST_RUN;
      ST_RUN:  w_run = 1'b1;
      default: w_state_nxt = ST_INIT;
    endcase
  end

  assign bus.pal_wr_ready = w_run && ((WR_ANYTIME != 0) || (32'(sy) >= 32'(V_RES)));
  assign w_pal_we         = bus.pal_wr_valid && bus.pal_wr_ready;

  // Default ramp: every channel carries the index scaled to the channel MSBs
  assign w_init_ch    = c_ch_w'(r_init_k) << (c_ch_w - INDEX_W);
  assign w_init_color = COLOR_W'({w_init_ch, w_init_ch, w_init_ch});

  always_ff @(posedge pixel_clk) begin
    if (r_state == ST_INIT)
      r_pal[r_init_k] <= w_init_color;
    else if (w_pal_we)
      r_pal[bus.pal_wr_index] <= bus.pal_wr_color;
  end

  // Mode only changes at the frame origin so a frame is never split
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n)
      r_scale <= 1'b0;
    else if (sx == '0 && sy == '0)
      r_scale <= scale2x;
  end

  always_comb begin
    w_row    = 32'(sy) >> r_scale;
    w_col    = 32'(sx) >> r_scale;
    w_wsrc   = 32'(H_RES) >> r_scale;
    w_addr   = w_row * w_wsrc + w_col;
    w_active = (32'(sx) < 32'(H_RES)) && (32'(sy) < 32'(V_RES));
    w_oob    = w_active && (w_addr >= 32'(FB_DEPTH));
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n)
      r_fb_addr <= '0;
    else if (w_run && w_active && !w_oob)
      r_fb_addr <= w_addr[FB_ADDR_W-1:0];
    else
      r_fb_addr <= '0;
  end

  assign bus.fb_addr = r_fb_addr;

  // Timing travels the full latency; oob only needs to reach the lookup stage
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_oob  <= '0;
    end else begin
      r_sync <= {r_sync[c_lat-2:0], {de_in, hsync_in, vsync_in}};
      r_oob  <= {r_oob[RAM_LATENCY-1:0], w_run && w_oob};
    end
  end

  assign w_de_lk  = r_sync[RAM_LATENCY][2];
  assign w_oob_lk = r_oob[RAM_LATENCY];

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n)
      r_color <= '0;
    else if (w_run && w_de_lk && !w_oob_lk)
      r_color <= r_pal[bus.fb_data];
    else
      r_color <= '0;
  end

  assign color                           = r_color;
  assign {de_out, hsync_out, vsync_out}  = r_sync[c_lat-1];

endmodule
`default_nettype wire

// File: tb/tb_vga_pixel_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tb_vga_pixel_pipe
// Brief   : Scoreboard bench for vga_pixel_pipe (800x480, 4-bit index, 15-bit
//           colour, FB_DEPTH 192000, RAM latency 1, blanking-only writes)
// Revision: 1.0 - initial release
// ============================================================================
module tb_vga_pixel_pipe;

  localparam int L = 3;

  typedef struct packed {
    int          t;
    logic [18:0] addr;
  } a_item_t;

  typedef struct packed {
    int          t;
    logic        de;
    logic        hs;
    logic        vs;
    logic        oob;
    logic        lit;
    logic [3:0]  idx;
    logic [14:0] col;
  } o_item_t;

  logic        pixel_clk = 1'b0;
  logic        rst_n     = 1'b0;
  logic [9:0]  sx        = '0;
  logic [9:0]  sy        = 10'd480;
  logic        de_in     = 1'b0;
  logic        hsync_in  = 1'b0;
  logic        vsync_in  = 1'b0;
  logic        scale2x   = 1'b0;
  logic [14:0] color;
  logic        de_out;
  logic        hsync_out;
  logic        vsync_out;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          pc      = 0;
  int          cur_sy  = 480;
  bit          sb_on   = 1'b0;
  bit          sc_req  = 1'b0;
  bit          scale_m = 1'b0;
  logic [3:0]  wr_idx  = 4'd3;
  logic [14:0] wr_col  = 15'h7C00;
  logic [14:0] pal_m [16];
  bit          pend_v  = 1'b0;
  logic [3:0]  pend_i;
  logic [14:0] pend_c;
  a_item_t     aq [$];
  o_item_t     oq [$];
  string       atq [$];
  string       otq [$];

  vga_pixel_pipe_if #(.INDEX_W(4), .COLOR_W(15), .FB_ADDR_W(19)) bus ();

  vga_pixel_pipe #(
    .H_RES(800), .V_RES(480), .INDEX_W(4), .COLOR_W(15),
    .FB_DEPTH(192000), .FB_ADDR_W(19), .RAM_LATENCY(1), .WR_ANYTIME(0)
  ) dut (
    .pixel_clk (pixel_clk),
    .rst_n     (rst_n),
    .sx        (sx),
    .sy        (sy),
    .de_in     (de_in),
    .hsync_in  (hsync_in),
    .vsync_in  (vsync_in),
    .scale2x   (scale2x),
    .bus       (bus),
    .color     (color),
    .de_out    (de_out),
    .hsync_out (hsync_out),
    .vsync_out (vsync_out)
  );

  always #5 pixel_clk = ~pixel_clk;

  always @(posedge pixel_clk) pc <= pc + 1;

  function automatic logic [3:0] ram_f(input logic [18:0] a);
    return a[3:0] + a[7:4] + 4'd3;
  endfunction

  always @(posedge pixel_clk) bus.fb_data <= ram_f(bus.fb_addr);

  function automatic logic [14:0] ramp(input int k);
    logic [4:0] ch;
    ch = 5'(k * 2);
    return {ch, ch, ch};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 16; k++) pal_m[k] = ramp(k);
    scale_m = 1'b0;
    pend_v  = 1'b0;
    aq.delete(); oq.delete(); atq.delete(); otq.delete();
  endtask

  // Drive one pixel and queue what must come out of the address and colour stages
  task automatic px(input int x, input int y, input bit de, input bit wv,
                    input string tag, input int a_l = -1, input int c_l = -1);
    a_item_t     ai;
    o_item_t     oi;
    bit          act;
    int          s;
    int          a;
    logic [18:0] ae;
    @(posedge pixel_clk); #1;
    sx       = 10'(x);
    sy       = 10'(y);
    de_in    = de;
    hsync_in = 1'($urandom);
    vsync_in = 1'($urandom);
    scale2x  = sc_req;
    bus.pal_wr_valid = wv;
    bus.pal_wr_index = wr_idx;
    bus.pal_wr_color = wr_col;
    cur_sy   = y;
    s   = int'(scale_m);
    act = (x < 800) && (y < 480);
    a   = act ? ((y >> s) * (800 >> s) + (x >> s)) : 0;
    oi.oob = act && (a >= 192000);
    ae     = oi.oob ? 19'd0 : 19'(a);
    ai.t    = pc + 1;
    ai.addr = (a_l >= 0) ? 19'(a_l) : ae;
    oi.t    = pc + L;
    oi.de   = de;
    oi.hs   = hsync_in;
    oi.vs   = vsync_in;
    oi.idx  = ram_f(ae);
    oi.lit  = (c_l >= 0);
    oi.col  = 15'(c_l);
    aq.push_back(ai);  atq.push_back({tag, "_addr"});
    oq.push_back(oi);  otq.push_back(tag);
    if (x == 0 && y == 0) scale_m = sc_req;
  endtask

  always @(negedge pixel_clk) begin : p_mon
    a_item_t     ai;
    o_item_t     oi;
    logic [14:0] ce;
    string       tg;
    if (sb_on) begin
      if (aq.size() > 0 && aq[0].t == pc) begin
        ai = aq.pop_front();
        tg = atq.pop_front();
        chk(tg, 32'(bus.fb_addr), 32'(ai.addr));
      end
      if (oq.size() > 0 && oq[0].t == pc) begin
        oi = oq.pop_front();
        tg = otq.pop_front();
        ce = oi.lit ? oi.col : ((oi.de && !oi.oob) ? pal_m[oi.idx] : 15'd0);
        chk({tg, "_col"}, 32'(color), 32'(ce));
        chk({tg, "_sync"}, 32'({de_out, hsync_out, vsync_out}), 32'({oi.de, oi.hs, oi.vs}));
      end
      chk("ready", 32'(bus.pal_wr_ready), 32'(cur_sy >= 480));
      // A write accepted at edge n is seen by lookups at edge n+1 onwards
      if (pend_v) pal_m[pend_i] = pend_c;
      pend_v = bus.pal_wr_valid && (cur_sy >= 480);
      pend_i = bus.pal_wr_index;
      pend_c = bus.pal_wr_color;
    end
  end

  task automatic drain(input string tag);
    for (int i = 0; i < 20 && (aq.size() > 0 || oq.size() > 0); i++)
      @(negedge pixel_clk);
    chk({tag, "_pending"}, 32'(aq.size() + oq.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.pal_wr_valid = 1'b0;
    bus.pal_wr_index = '0;
    bus.pal_wr_color = '0;
    model_reset();

    repeat (3) @(posedge pixel_clk);
    @(negedge pixel_clk);
    chk("rst_fb_addr", 32'(bus.fb_addr), 32'd0);
    chk("rst_color",   32'(color), 32'd0);
    chk("rst_de",      32'(de_out), 32'd0);
    chk("rst_hs",      32'(hsync_out), 32'd0);
    chk("rst_vs",      32'(vsync_out), 32'd0);
    chk("rst_ready",   32'(bus.pal_wr_ready), 32'd0);

    @(posedge pixel_clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge pixel_clk);
      chk("init_ready", 32'(bus.pal_wr_ready), 32'd0);
      chk("init_color", 32'(color), 32'd0);
    end
    @(negedge pixel_clk);
    chk("run_ready", 32'(bus.pal_wr_ready), 32'd1);
    sb_on = 1'b1;

    sc_req = 1'b0;
    px(0, 0, 1, 0, "frame1");
    px(2, 0, 1, 0, "pal5", -1, 15'h294A);
    px(10, 2, 1, 0, "addr1x", 1610);
    px(0, 240, 1, 0, "oob", 0, 0);
    px(799, 239, 1, 0, "edge_in");
    px(800, 2, 0, 0, "hblank", 0);
    sc_req = 1'b1;
    px(300, 3, 1, 0, "no_tear", 2700);
    for (int i = 0; i < 5; i++) begin
      int x, y;
      x = $urandom_range(850, 1);
      y = $urandom_range(500, 1);
      px(x, y, (x < 800 && y < 480), 0, "rnd1");
    end

    wr_idx = 4'd3;
    wr_col = 15'h7C00;
    for (int i = 0; i < 3; i++)
      px($urandom_range(799, 1), 100, 1, 1, "holdoff");
    px(0, 480, 0, 1, "wr_acc");
    px(0, 480, 1, 0, "wr_vis", -1, 15'h7C00);
    px(0, 480, 1, 0, "same_old", -1, 15'h7C00);
    px(0, 480, 1, 0, "next_new", -1, 15'h03E0);
    wr_col = 15'h03E0;
    px(0, 480, 0, 1, "wr_same");
    px(0, 480, 0, 0, "idle");

    px(0, 0, 1, 0, "frame2");
    px(21, 5, 1, 0, "addr2x", 810);
    for (int i = 0; i < 15; i++) begin
      int x, y;
      x = $urandom_range(850, 1);
      y = $urandom_range(500, 1);
      px(x, y, (x < 800 && y < 480), 0, "rnd2");
    end
    sc_req = 1'b0;
    px(0, 0, 1, 0, "frame3");
    for (int i = 0; i < 15; i++) begin
      int x, y;
      x = $urandom_range(850, 1);
      y = $urandom_range(500, 1);
      px(x, y, (x < 800 && y < 480), 0, "rnd3");
    end
    for (int i = 0; i < 4; i++) px(0, 480, 0, 0, "idle");
    drain("run1");
    #1;
    sb_on = 1'b0;

    @(posedge pixel_clk); #1;
    sx = '0; sy = 10'd480; de_in = 1'b1; hsync_in = 1'b1; vsync_in = 1'b0;
    repeat (3) @(posedge pixel_clk);
    @(negedge pixel_clk);
    chk("pre_rst_de",  32'(de_out), 32'd1);
    chk("pre_rst_col", 32'(color), 32'(pal_m[3]));
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_de",    32'(de_out), 32'd0);
    chk("arst_hs",    32'(hsync_out), 32'd0);
    chk("arst_color", 32'(color), 32'd0);
    chk("arst_ready", 32'(bus.pal_wr_ready), 32'd0);
    de_in = 1'b0; hsync_in = 1'b0;
    repeat (2) @(posedge pixel_clk); #1;
    rst_n = 1'b1;
    model_reset();
    repeat (7) @(posedge pixel_clk); #1;
    chk("mid_init_ready", 32'(bus.pal_wr_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_init_fb_addr", 32'(bus.fb_addr), 32'd0);
    chk("mid_init_color",   32'(color), 32'd0);
    @(posedge pixel_clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge pixel_clk);
      chk("reinit_ready", 32'(bus.pal_wr_ready), 32'd0);
      chk("reinit_color", 32'(color), 32'd0);
    end
    @(negedge pixel_clk);
    chk("rerun_ready", 32'(bus.pal_wr_ready), 32'd1);
    sb_on = 1'b1;

    // Address (j+13)%16 on line 0 makes the RAM return index j
    for (int j = 0; j < 16; j++)
      px((j + 13) % 16, 0, 1, 0, "ramp");
    for (int i = 0; i < 4; i++) px(0, 480, 0, 0, "idle");
    drain("run2");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
